// File: rtl/int_calc_pkg.sv
// Shared definitions for the multi-cycle integer calculator: operation codes,
// FSM state encoding and the default datapath width.
package int_calc_pkg;

  localparam int DEFAULT_WIDTH = 64;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_POW = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_POW_MUL,
    ST_POW_SQR,
    ST_FIN
  } state_t;

endpackage

// File: rtl/int_calc_mc_seq_mul.sv
// Iterative shift-add multiplier, WIDTH-bit truncated product. The first
// partial product is folded into the load edge so valid is sampled WIDTH edges after load.
module seq_mul
  import int_calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  // NOTE: only the handshake flags are reset; the operand and product
  // registers are always written by load before anyone looks at them.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (load) begin
        product <= b[0] ? a : '0;
        mcand   <= a << 1;
        mplier  <= b >> 1;
        cnt     <= CW'(WIDTH - 2);
        busy    <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
        if (cnt == '0) begin
          busy  <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/int_calc_mc.sv
// Multi-cycle unsigned integer calculator: add/sub in one step, mul and pow on
// a shared sequential multiplier, div/mod on a restoring divider.
module int_calc_mc
  import int_calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             dbz,
  output logic             err
);

  localparam int               CW  = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] rem_q, quo_q;
  logic [WIDTH-1:0] acc_q, base_q, exp_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             exp_more;
  logic             mul_req, mul_load, mul_busy, mul_valid;
  logic [WIDTH-1:0] mul_a, mul_b, mul_p;
  logic [WIDTH:0]   rem_shift, rem_diff;
  logic [WIDTH-1:0] rem_next, quo_next;

  assign accept   = start && ready;
  // Exponent bits above the one being processed: decides whether a square follows.
  assign exp_more = |exp_q[WIDTH-1:1];
  assign mul_load = mul_req && !mul_busy;

  // One restoring-division step; borrow out of the extra bit means "does not fit".
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, b_q};
    if (!rem_diff[WIDTH]) begin
      rem_next = rem_diff[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_shift[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Multiplier operands are muxed so the next pow step loads on the same edge
  // the previous product completes, using the fresh product directly.
  always_comb begin
    mul_req = 1'b0;
    mul_a   = '0;
    mul_b   = '0;
    case (state)
      ST_IDLE: begin
        if (accept && operation == OP_MUL) begin
          mul_req = 1'b1;
          mul_a   = opa;
          mul_b   = opb;
        end else if (accept && operation == OP_POW && opb != '0) begin
          mul_req = 1'b1;
          mul_a   = opb[0] ? ONE : opa;
          mul_b   = opa;
        end
      end
      ST_POW_MUL: begin
        if (mul_valid && exp_more) begin
          mul_req = 1'b1;
          mul_a   = base_q;
          mul_b   = base_q;
        end
      end
      ST_POW_SQR: begin
        if (mul_valid) begin
          mul_req = 1'b1;
          mul_a   = exp_q[1] ? acc_q : mul_p;
          mul_b   = mul_p;
        end
      end
      default: ;
    endcase
  end

  seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .a       (mul_a),
    .b       (mul_b),
    .busy    (mul_busy),
    .valid   (mul_valid),
    .product (mul_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      out   <= '0;
      dbz   <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= operation;
            a_q    <= opa;
            b_q    <= opb;
            dbz    <= 1'b0;
            err    <= 1'b0;
            ready  <= 1'b0;
            quo_q  <= opa;
            rem_q  <= '0;
            cnt_q  <= CW'(WIDTH - 1);
            acc_q  <= ONE;
            base_q <= opa;
            exp_q  <= opb;
            case (operation)
              OP_MUL:         state <= ST_MUL;
              OP_DIV, OP_MOD: state <= (opb == '0) ? ST_FIN : ST_DIV;
              OP_POW:         state <= (opb == '0) ? ST_FIN
                                     : (opb[0] ? ST_POW_MUL : ST_POW_SQR);
              default:        state <= ST_FIN;
            endcase
          end
        end
        ST_MUL: begin
          if (mul_valid) state <= ST_FIN;
        end
        ST_DIV: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state <= ST_FIN;
        end
        ST_POW_MUL: begin
          if (mul_valid) begin
            acc_q <= mul_p;
            state <= exp_more ? ST_POW_SQR : ST_FIN;
          end
        end
        ST_POW_SQR: begin
          if (mul_valid) begin
            base_q <= mul_p;
            exp_q  <= exp_q >> 1;
            state  <= exp_q[1] ? ST_POW_MUL : ST_POW_SQR;
          end
        end
        ST_FIN: begin
          done  <= 1'b1;
          ready <= 1'b1;
          state <= ST_IDLE;
          case (op_q)
            OP_ADD: out <= a_q + b_q;
            OP_SUB: out <= a_q - b_q;
            OP_MUL: out <= mul_p;
            OP_DIV: begin
              out <= (b_q == '0) ? '1 : quo_q;
              dbz <= (b_q == '0);
            end
            OP_MOD: begin
              out <= (b_q == '0) ? a_q : rem_q;
              dbz <= (b_q == '0);
            end
            OP_POW: out <= acc_q;
            default: begin
              out <= '0;
              err <= 1'b1;
            end
          endcase
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/int_calc_mc.md
# int_calc_mc

Parametrised multi-cycle integer calculator with a start/done handshake. It performs add, subtract, multiply, divide, modulo and power on WIDTH-bit unsigned operands. Multiply, divide and power run on iterative shift-based datapaths, so no wide combinational multiplier or divider is needed. It sits beside the floating-point unit in the arithmetic path and is driven by the same operation-select controller.

## Interface
- WIDTH, 64: operand and result width in bits; minimum 4.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only on an edge where ready=1.
- operation  in  3  000 add, 001 sub, 010 mul, 011 div, 100 mod, 101 pow; 110 and 111 are invalid.
- opa  in  WIDTH  operand A, unsigned.
- opb  in  WIDTH  operand B, unsigned; also the exponent for pow.
- ready  out  1  idle and able to accept start.
- done  out  1  one-cycle pulse when out is valid.
- out  out  WIDTH  result; holds its value until the next done.
- dbz  out  1  divide by zero; valid with done, held until the next accepted start.
- err  out  1  invalid operation; valid with done, held until the next accepted start.

## Operation
- States: IDLE, MUL, DIV, POW_MUL, POW_SQR, FIN.
- IDLE: ready=1.
  - Accepted start latches opa, opb and operation, and clears dbz and err.
  - Start while ready=0 is ignored; operands are not re-latched.
- add/sub/invalid: go IDLE→FIN.
  - Results are modulo 2^WIDTH; borrow and carry are discarded.
  - Invalid op gives out=0, err=1.
- mul: shift-add, one opb bit per cycle, WIDTH cycles in MUL, then FIN. Low WIDTH bits of the product only.
- div/mod: restoring division, one quotient bit per cycle, WIDTH cycles in DIV, then FIN.
  - div outputs the quotient; mod outputs the remainder.
  - opb=0: skip DIV and go to FIN with dbz=1. out is all-ones for div and opa for mod.
- pow: right-to-left square-and-multiply.
  - Start with acc=1, base=opa, and scan exponent bits k=0..m, where m is the index of the highest set bit of opb.
  - Bit k set: acc=acc*base (POW_MUL, WIDTH cycles).
  - k<m: base=base*base (POW_SQR, WIDTH cycles).
  - All products are truncated to WIDTH bits.
  - opb=0: out=1 via FIN directly, including 0^0=1.
- FIN: register out, pulse done, return to IDLE with ready=1 in the same cycle that done=1.

## Timing
- Start accepted at edge N. done=1 and out are valid during the cycle after edge N+L.
  - add, sub, invalid, div/mod with opb=0, pow with opb=0: L=1.
  - mul, div, mod: L=WIDTH+1.
  - pow: L=1+WIDTH*(popcount(opb)+m).
- ready drops the cycle after acceptance and rises together with done. A start asserted during the done cycle is accepted back-to-back.
- Reset values: ready=1, done=0, out=0, dbz=0, err=0, state IDLE.
- rst mid-operation aborts the operation. No done is produced, out returns to 0, and ready=1 the cycle after the reset edge.
- Operand changes after acceptance have no effect.

## Structure
- Package int_calc_pkg holds:
  - the op encodings OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_POW;
  - the state encoding;
  - the default WIDTH.
- Sub-module seq_mul: WIDTH-bit shift-add multiplier with a load/busy/valid interface and WIDTH-cycle latency.
  - Shared by mul, POW_MUL and POW_SQR. The top FSM sequences it.
- The divider and add/sub stay in the top module.

## Test plan
- WIDTH=64, add: opa=0xFFFF_FFFF_FFFF_FFFF, opb=1 → out=0, done one cycle after acceptance, dbz=0, err=0.
- mul: opa=0x1_0000_0001, opb=0x1_0000_0000 → out=0x0000_0001_0000_0000 with L=65. sub: opa=3, opb=5 → out=0xFFFF_FFFF_FFFF_FFFE with L=1.
- div: 100/7 → out=14. mod: 100%7 → 2 (L=65 each). div: 9/0 → out=all-ones, dbz=1, L=1. mod: 9%0 → out=9, dbz=1.
- pow: 3^5 → out=243, L=1+64*(2+2)=257. pow: 2^64 → out=0. pow: 7^0 → out=1, L=1.
- Handshake:
  - start pulsed again mid-mul with different operands → ignored, first result correct.
  - start held through done → second op accepted back-to-back.
  - rst asserted mid-div → no done, ready=1 and out=0 next cycle.
- operation=3'b111 → out=0, err=1, done with L=1. The next valid op clears err at acceptance.
